mcal_date_counter: RTL

//  Sequential Darian (Martian) calendar: holds year/month/sol, advances one sol per tick.

---
 rtl/mcal_pkg.sv | 37 +++
 rtl/mcal_month_len.sv | 21 ++
 rtl/mcal_date_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mcal_pkg.sv
// mcal_pkg: shared types and calendar rules for the Darian date counter.
//   NUM_MONTHS  months per Darian year (0..23)
//   month_t     5-bit month index
//   sol_t       5-bit sol-of-month (1-based)
//   is_leap     leap-year rule
//   month_len   month length in sols for a given month and leap flag
package mcal_pkg;

  localparam int unsigned NUM_MONTHS = 24;

  typedef logic [4:0] month_t;
  typedef logic [4:0] sol_t;

  localparam month_t LAST_MONTH = month_t'(NUM_MONTHS - 1);
  localparam sol_t   LEN_SHORT  = 5'd27;
  localparam sol_t   LEN_LONG   = 5'd28;

  // Odd years are leap; even years are leap only on decades, with the
  // century exception itself overridden every 500 years.
  function automatic logic is_leap(input logic [31:0] y);
    logic dec, cen, q500;
    dec  = ((y % 32'd10) == 32'd0);
    cen  = ((y % 32'd100) == 32'd0);
    q500 = ((y % 32'd500) == 32'd0);
    return y[0] | (dec & (~cen | q500));
  endfunction

  // Every sixth month is short; the final month gains a sol in leap years.
  function automatic sol_t month_len(input month_t m, input logic ly);
    if ((m == LAST_MONTH) && ly)
      return LEN_LONG;
    if ((32'(m) % 32'd6) == 32'd5)
      return LEN_SHORT;
    return LEN_LONG;
  endfunction

endpackage

// File: rtl/mcal_month_len.sv
// mcal_month_len: combinational month-length decode.
//   i_month  month index 0..23
//   i_leap   year is leap
//   o_d27    month is 27 sols long
//   o_d28    month is 28 sols long
module mcal_month_len
  import mcal_pkg::*;
(
  input  month_t i_month,
  input  logic   i_leap,
  output logic   o_d27,
  output logic   o_d28
);

  sol_t w_len;

  assign w_len = month_len(i_month, i_leap);
  assign o_d27 = (w_len == LEN_SHORT);
  assign o_d28 = (w_len == LEN_LONG);

endmodule

// File: rtl/mcal_date_counter.sv
// mcal_date_counter: Darian calendar year/month/sol counter, one sol per tick.
//   clk, rst            clock; synchronous active-high reset
//   tick                advance one sol
//   load                load load_year/load_month/load_sol (priority over tick)
//   load_year/month/sol date to load; rejected with load_err if invalid
//   dir                 0=forward, 1=backward (only with MCAL_DEC_EN)
//   year, month, sol    current date
//   leap, d27, d28      current year leap flag, one-hot month length
//   new_month, new_year 1-cycle pulses on tick-driven rollovers
//   load_err            1-cycle pulse on rejected load
// Build option: define MCAL_DEC_EN to enable backward ticking via dir.
module mcal_date_counter
  import mcal_pkg::*;
#(
  parameter int unsigned YEAR_W    = 12,
  parameter int unsigned INIT_YEAR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [YEAR_W-1:0] load_year,
  input  logic [4:0]        load_month,
  input  logic [4:0]        load_sol,
  input  logic              dir,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        month,
  output logic [4:0]        sol,
  output logic              leap,
  output logic              d27,
  output logic              d28,
  output logic              new_month,
  output logic              new_year,
  output logic              load_err
);

  logic [YEAR_W-1:0] r_year;
  month_t            r_month;
  sol_t              r_sol;
  logic              r_new_month;
  logic              r_new_year;
  logic              r_load_err;

  logic [YEAR_W-1:0] w_year_n;
  month_t            w_month_n;
  sol_t              w_sol_n;
  logic              w_new_month_n;
  logic              w_new_year_n;
  logic              w_load_err_n;

  logic              w_leap;
  logic              w_d27;
  logic              w_d28;
  sol_t              w_cur_len;

  logic              w_ld_leap;
  logic              w_ld_d27;
  logic              w_ld_d28;
  sol_t              w_ld_len;
  logic              w_load_ok;

  assign w_leap = is_leap(32'(r_year));

  mcal_month_len u_len_cur (
    .i_month (r_month),
    .i_leap  (w_leap),
    .o_d27   (w_d27),
    .o_d28   (w_d28)
  );

  assign w_cur_len = w_d27 ? LEN_SHORT : LEN_LONG;

  // Validation uses the leap flag of the year being loaded, not the current one.
  assign w_ld_leap = is_leap(32'(load_year));

  mcal_month_len u_len_load (
    .i_month (load_month),
    .i_leap  (w_ld_leap),
    .o_d27   (w_ld_d27),
    .o_d28   (w_ld_d28)
  );

  assign w_ld_len  = w_ld_d27 ? LEN_SHORT : LEN_LONG;
  assign w_load_ok = (load_month <= LAST_MONTH) && (load_sol != '0) &&
                     (load_sol <= w_ld_len);

`ifdef MCAL_DEC_EN
  logic [YEAR_W-1:0] w_year_dec;
  month_t            w_month_dec;
  sol_t              w_prev_len;

  assign w_year_dec  = r_year - 1'b1;
  assign w_month_dec = (r_month == '0) ? LAST_MONTH : (r_month - 5'd1);
  // Stepping back out of month 0 lands in the previous year's last month,
  // so its length depends on that year's leap flag.
  assign w_prev_len  = (r_month == '0) ? month_len(w_month_dec, is_leap(32'(w_year_dec)))
                                       : month_len(w_month_dec, w_leap);
`else
  logic w_unused_dir;
  assign w_unused_dir = dir ^ w_d28 ^ w_ld_d28;
`endif

  always_comb begin
    w_year_n      = r_year;
    w_month_n     = r_month;
    w_sol_n       = r_sol;
    w_new_month_n = 1'b0;
    w_new_year_n  = 1'b0;
    w_load_err_n  = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_year_n  = load_year;
        w_month_n = load_month;
        w_sol_n   = load_sol;
      end else begin
        w_load_err_n = 1'b1;
      end
    end else if (tick) begin
`ifdef MCAL_DEC_EN
      if (dir) begin
        if (r_sol > 5'd1) begin
          w_sol_n = r_sol - 5'd1;
        end else begin
          w_sol_n       = w_prev_len;
          w_month_n     = w_month_dec;
          w_new_month_n = 1'b1;
          if (r_month == '0) begin
            w_year_n     = w_year_dec;
            w_new_year_n = 1'b1;
          end
        end
      end else
`endif
      begin
        if (r_sol < w_cur_len) begin
          w_sol_n = r_sol + 5'd1;
        end else begin
          w_sol_n       = 5'd1;
          w_new_month_n = 1'b1;
          if (r_month == LAST_MONTH) begin
            w_month_n    = '0;
            w_year_n     = r_year + 1'b1;
            w_new_year_n = 1'b1;
          end else begin
            w_month_n = r_month + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_year      <= YEAR_W'(INIT_YEAR);
      r_month     <= '0;
      r_sol       <= 5'd1;
      r_new_month <= 1'b0;
      r_new_year  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_year      <= w_year_n;
      r_month     <= w_month_n;
      r_sol       <= w_sol_n;
      r_new_month <= w_new_month_n;
      r_new_year  <= w_new_year_n;
      r_load_err  <= w_load_err_n;
    end
  end

  assign year      = r_year;
  assign month     = r_month;
  assign sol       = r_sol;
  assign leap      = w_leap;
  assign d27       = w_d27;
  assign d28       = w_d28;
  assign new_month = r_new_month;
  assign new_year  = r_new_year;
  assign load_err  = r_load_err;

endmodule
